// File: rtl/shiftleft_26bit.sv
`default_nettype none
// ============================================================================
// Module   : shiftleft_26bit
// Function : Registered constant left shift for the MIPS jump-address path.
//            Turns the 26-bit J-type instruction index into a byte offset
//            (i << SHIFT, truncated to WIDTH bits) with a valid bit and a
//            flag showing that non-zero bits were shifted out of the top.
//            One cycle of latency, one result per cycle, stall on en=0.
// Options  : SHIFTLEFT_26BIT_JADDR_EN - adds pc_hi input and jaddr output
//            carrying the full, untruncated jump target {pc_hi, i, 00}.
// Revision : 1.0 - initial release
// ============================================================================
module shiftleft_26bit #(
  parameter int WIDTH = 26,
  parameter int SHIFT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   i_valid,
  input  logic [WIDTH-1:0]       i,
`ifdef SHIFTLEFT_26BIT_JADDR_EN
  input  logic [3:0]             pc_hi,
  output logic [WIDTH+SHIFT+3:0] jaddr,
`endif
  output logic [WIDTH-1:0]       o,
  output logic                   o_valid,
  output logic                   o_lost
);

  // Width of the optional full jump target: 4 PC bits, the index, the zeros.
  localparam int C_JADDR_W = WIDTH + SHIFT + 4;

  // Combinational shift result and lost-bit detection
  logic [WIDTH-1:0] w_shifted;
  logic             w_lost_bits;

  // Next-state values for the output stage
  logic [WIDTH-1:0] w_data_d;
  logic             w_valid_d;
  logic             w_lost_d;

  // Output stage registers
  logic [WIDTH-1:0] r_data_q;
  logic             r_valid_q;
  logic             r_lost_q;

  // Shifting a WIDTH-bit value keeps WIDTH bits, so the top SHIFT bits of i
  // drop off and the low SHIFT bits fill with zeros.
  assign w_shifted = i << SHIFT;

  // A zero shift discards nothing; otherwise OR together the discarded MSBs.
  // The split keeps the part-select legal when SHIFT is 0.
  generate
    if (SHIFT == 0) begin : g_lost_none
      assign w_lost_bits = 1'b0;
    end else begin : g_lost_msbs
      assign w_lost_bits = |i[WIDTH-1 -: SHIFT];
    end
  endgenerate

  // Next-state selection: load on en, otherwise hold everything (stall).
  // Data and lost flag load regardless of i_valid; consumers qualify with o_valid.
  always_comb begin
    w_data_d  = r_data_q;
    w_valid_d = r_valid_q;
    w_lost_d  = r_lost_q;
    if (en) begin
      w_data_d  = w_shifted;
      w_valid_d = i_valid;
      w_lost_d  = w_lost_bits;
    end
  end

  // Output stage; asynchronous reset discards any in-flight result at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
      r_lost_q  <= 1'b0;
    end else begin
      r_data_q  <= w_data_d;
      r_valid_q <= w_valid_d;
      r_lost_q  <= w_lost_d;
    end
  end

  assign o       = r_data_q;
  assign o_valid = r_valid_q;
  assign o_lost  = r_lost_q;

`ifdef SHIFTLEFT_26BIT_JADDR_EN
  // Full jump target: widening before the shift keeps every index bit.
  logic [C_JADDR_W-1:0] w_jaddr_full;
  logic [C_JADDR_W-1:0] w_jaddr_d;
  logic [C_JADDR_W-1:0] r_jaddr_q;

  assign w_jaddr_full = C_JADDR_W'({pc_hi, i}) << SHIFT;

  // Jump-target next state follows the same enable as the data path.
  always_comb begin
    w_jaddr_d = r_jaddr_q;
    if (en) begin
      w_jaddr_d = w_jaddr_full;
    end
  end

  // Jump-target register shares the stage's reset and stall behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_jaddr_q <= '0;
    end else begin
      r_jaddr_q <= w_jaddr_d;
    end
  end

  assign jaddr = r_jaddr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shiftleft_26bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_shiftleft_26bit
// Function : Directed self-checking bench for shiftleft_26bit (defaults
//            WIDTH=26, SHIFT=2). Optional SHIFTLEFT_26BIT_JADDR_EN adds the
//            jump-target check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shiftleft_26bit;

  localparam int WIDTH = 26;
  localparam int SHIFT = 2;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             i_valid;
  logic [WIDTH-1:0] i;
  logic [WIDTH-1:0] o;
  logic             o_valid;
  logic             o_lost;
`ifdef SHIFTLEFT_26BIT_JADDR_EN
  logic [3:0]             pc_hi;
  logic [WIDTH+SHIFT+3:0] jaddr;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  shiftleft_26bit #(
    .WIDTH (WIDTH),
    .SHIFT (SHIFT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .i_valid (i_valid),
    .i       (i),
`ifdef SHIFTLEFT_26BIT_JADDR_EN
    .pc_hi   (pc_hi),
    .jaddr   (jaddr),
`endif
    .o       (o),
    .o_valid (o_valid),
    .o_lost  (o_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and on mismatch count and report it.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check all three outputs at once.
  task automatic check_out(input string tag, input logic [25:0] eo, input logic ev, input logic el);
    check({tag, ".o"},       {6'd0, o},        {6'd0, eo});
    check({tag, ".o_valid"}, {31'd0, o_valid}, {31'd0, ev});
    check({tag, ".o_lost"},  {31'd0, o_lost},  {31'd0, el});
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with all-ones input and en=1: reset must win.
    rst_n   = 1'b0;
    en      = 1'b1;
    i_valid = 1'b1;
    i       = 26'h3FFFFFF;
`ifdef SHIFTLEFT_26BIT_JADDR_EN
    pc_hi   = 4'hF;
`endif
    #1;
    check_out("rst_async", 26'h0, 1'b0, 1'b0);
    step();
    step();
    check_out("rst_clk", 26'h0, 1'b0, 1'b0);
`ifdef SHIFTLEFT_26BIT_JADDR_EN
    check("rst_jaddr", jaddr, 32'h0);
`endif

    // Release reset away from the edge, then stream directed vectors.
    rst_n = 1'b1;
    i     = 26'h0000000;
    step();
    check_out("zero", 26'h0000000, 1'b1, 1'b0);

    i = 26'h3FFFFFF;
    step();
    check_out("ones", 26'h3FFFFFC, 1'b1, 1'b1);

    i = 26'h3FFFFFC;
    step();
    check_out("ones_lo0", 26'h3FFFFF0, 1'b1, 1'b1);

    i = 26'h0FFFFFF;
    step();
    check_out("top2_zero", 26'h3FFFFFC, 1'b1, 1'b0);

    // Stall: input changes are ignored while en=0.
    en      = 1'b0;
    i       = 26'h0000001;
    i_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_out("stall", 26'h3FFFFFC, 1'b1, 1'b0);
    end
    en      = 1'b1;
    i_valid = 1'b1;
    step();
    check_out("unstall", 26'h0000004, 1'b1, 1'b0);

    // Valid pattern 1,0,1; data and lost still update while invalid.
    i_valid = 1'b1;
    i       = 26'h0000005;
    step();
    check_out("vpat1", 26'h0000014, 1'b1, 1'b0);
    i_valid = 1'b0;
    i       = 26'h2000006;
    step();
    check_out("vpat0", 26'h0000018, 1'b0, 1'b1);
    i_valid = 1'b1;
    i       = 26'h2000000;
    step();
    check_out("vpat1b", 26'h0000000, 1'b1, 1'b1);

    // Boundary bits: bit 24 is discarded, bit 23 lands on the MSB.
    i = 26'h1000000;
    step();
    check_out("bit24", 26'h0000000, 1'b1, 1'b1);
    i = 26'h0800000;
    step();
    check_out("bit23", 26'h2000000, 1'b1, 1'b0);

    // Mid-cycle reset pulse clears outputs before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_out("rst_mid", 26'h0, 1'b0, 1'b0);
    step();
    check_out("rst_mid_hold", 26'h0, 1'b0, 1'b0);
    rst_n   = 1'b1;
    i_valid = 1'b0;
    i       = 26'h0000003;
    step();
    check_out("post_rst_inv", 26'h000000C, 1'b0, 1'b0);
    i_valid = 1'b1;
    i       = 26'h0000007;
    step();
    check_out("post_rst_val", 26'h000001C, 1'b1, 1'b0);

`ifdef SHIFTLEFT_26BIT_JADDR_EN
    // Full jump target including the PC upper nibble.
    pc_hi = 4'hA;
    i     = 26'h0000010;
    step();
    check("jaddr_a", jaddr, 32'hA0000040);
    check_out("jaddr_o", 26'h0000040, 1'b1, 1'b0);
    en    = 1'b0;
    pc_hi = 4'h5;
    i     = 26'h3FFFFFF;
    step();
    check("jaddr_stall", jaddr, 32'hA0000040);
    en = 1'b1;
    step();
    check("jaddr_full", jaddr, 32'h5FFFFFFC);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
